// File: rtl/ultrasonic_pkg.sv
// Shared encodings, constants and cycle-count helpers for the ultrasonic ranger.
// Every derived count scales from whole clocks per microsecond.
package ultrasonic_pkg;

  localparam logic [3:0] ST_TRIG_ENC    = 4'b0001;
  localparam logic [3:0] ST_WAIT_ENC    = 4'b0010;
  localparam logic [3:0] ST_MEASURE_ENC = 4'b0100;
  localparam logic [3:0] ST_DONE_ENC    = 4'b1000;

  typedef enum logic [3:0] {
    ST_TRIG      = ST_TRIG_ENC,
    ST_WAIT_ECHO = ST_WAIT_ENC,
    ST_MEASURE   = ST_MEASURE_ENC,
    ST_DONE      = ST_DONE_ENC
  } state_e;

  localparam logic [19:0] FAR_DIST  = 20'hFFFFF;
  localparam logic [19:0] CM_SAT    = 20'hFFFFE;
  localparam int          US_PER_CM = 58;

  function automatic int clk_per_us(input int clk_freq);
    return clk_freq / 1_000_000;
  endfunction

  function automatic int trig_cycles(input int clk_freq, input int trig_us);
    return clk_per_us(clk_freq) * trig_us;
  endfunction

  function automatic int cm_cycles(input int clk_freq);
    return clk_per_us(clk_freq) * US_PER_CM;
  endfunction

  function automatic int period_cycles(input int clk_freq, input int period_ms);
    return clk_per_us(clk_freq) * 1000 * period_ms;
  endfunction

  function automatic int timeout_cycles(input int clk_freq, input int timeout_ms);
    return clk_per_us(clk_freq) * 1000 * timeout_ms;
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchroniser plus edge detector for an asynchronous level input.
// rise/fall are single-cycle pulses aligned with the synchronised level echo_s.
module echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic echo_s,
  output logic rise,
  output logic fall
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign echo_s = sync2_q;
  assign rise   = sync2_q & ~prev_q;
  assign fall   = ~sync2_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo timing and divider-free
// conversion of echo width to whole centimetres with a one-cycle valid strobe.
module ultrasonic_ranger
  import ultrasonic_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_MS = 38
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        echo,
  output logic        trig,
  output logic [19:0] disten,
  output logic        dist_valid,
  output logic        timeout
);

  localparam int TRIG_CYC    = trig_cycles(CLK_FREQ, TRIG_US);
  localparam int CM_CYC      = cm_cycles(CLK_FREQ);
  localparam int PERIOD_CYC  = period_cycles(CLK_FREQ, PERIOD_MS);
  localparam int TIMEOUT_CYC = timeout_cycles(CLK_FREQ, TIMEOUT_MS);

  localparam int TRIG_W = $clog2(TRIG_CYC + 1);
  localparam int SUB_W  = $clog2(CM_CYC);
  localparam int PER_W  = $clog2(PERIOD_CYC);
  localparam int TO_W   = $clog2(TIMEOUT_CYC);

  localparam logic [TRIG_W-1:0] TRIG_END = TRIG_W'(TRIG_CYC);
  localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(CM_CYC - 1);
  localparam logic [PER_W-1:0]  PER_LAST = PER_W'(PERIOD_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYC - 1);

  state_e             state_q, state_d;
  logic [TRIG_W-1:0]  trig_cnt_q, trig_cnt_d;
  logic [PER_W-1:0]   per_q, per_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [SUB_W-1:0]   sub_q, sub_d;
  logic [19:0]        cm_q, cm_d;
  logic               trig_q, trig_d;
  logic [19:0]        disten_q, disten_d;
  logic               timeout_q, timeout_d;
  logic               valid_q, valid_d;

  logic echo_s;
  logic rise;
  logic fall;
  logic to_hit;

  echo_sync u_echo_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (echo),
    .echo_s (echo_s),
    .rise   (rise),
    .fall   (fall)
  );

  assign to_hit = (to_cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_TRIG;
      trig_cnt_q <= '0;
      per_q      <= '0;
      to_cnt_q   <= '0;
      sub_q      <= '0;
      cm_q       <= '0;
      trig_q     <= 1'b0;
      disten_q   <= FAR_DIST;
      timeout_q  <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      per_q      <= per_d;
      to_cnt_q   <= to_cnt_d;
      sub_q      <= sub_d;
      cm_q       <= cm_d;
      trig_q     <= trig_d;
      disten_q   <= disten_d;
      timeout_q  <= timeout_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = '0;
    to_cnt_d   = '0;
    sub_d      = sub_q;
    cm_d       = cm_q;
    trig_d     = 1'b0;
    disten_d   = disten_q;
    timeout_d  = timeout_q;
    valid_d    = 1'b0;
    per_d      = (per_q == PER_LAST) ? '0 : per_q + PER_W'(1);

    case (state_q)
      // trig_q lags the count by one edge, so the pin is high for exactly TRIG_CYC cycles
      ST_TRIG: begin
        if (trig_cnt_q == TRIG_END) begin
          state_d = ST_WAIT_ECHO;
        end else begin
          trig_cnt_d = trig_cnt_q + TRIG_W'(1);
          trig_d     = 1'b1;
        end
      end
      ST_WAIT_ECHO: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (to_hit) begin
          disten_d  = FAR_DIST;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = ST_DONE;
        end else if (rise) begin
          sub_d   = '0;
          cm_d    = '0;
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          if (cm_q != CM_SAT) cm_d = cm_q + 20'd1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
        // the fall cycle itself is part of the width, hence cm_d rather than cm_q
        if (fall) begin
          disten_d  = cm_d;
          timeout_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = ST_DONE;
        end else if (to_hit) begin
          disten_d  = FAR_DIST;
          timeout_d = 1'b1;
          valid_d   = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        if ((per_q == PER_LAST) && !echo_s) state_d = ST_TRIG;
      end
      default: state_d = ST_TRIG;
    endcase
  end

  assign trig       = trig_q;
  assign disten     = disten_q;
  assign dist_valid = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Scoreboard bench for ultrasonic_ranger, scaled to 1 clock per microsecond
// (trigger 10, cm 58, period 4000, timeout 3000 cycles).
module tb_ultrasonic_ranger;

  localparam int TC = 10;
  localparam int P  = 4000;
  localparam int T  = 3000;
  localparam logic [19:0] FAR = 20'hFFFFF;
  localparam int NROW = 10;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        echo  = 1'b0;
  logic        trig;
  logic [19:0] disten;
  logic        dist_valid;
  logic        timeout;

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [19:0] d;
    logic        to;
    int          c;
  } exp_t;

  exp_t exp_q[$];
  int   trig_q[$];

  // rise offset from trig fall, echo width (0 = no echo), expected result, held past period end
  int   roff  [NROW] = '{5, 5, 0, 5, 5, 5, 5, -2, -2, 5};
  int   wid   [NROW] = '{1450, 1449, 0, 2900, 2900, 2900, 4100, 2999, 3000, 1450};
  int   exp_d [NROW] = '{25, 24, 'hFFFFF, 50, 50, 50, 'hFFFFF, 51, 'hFFFFF, 25};
  logic exp_to[NROW] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic hold  [NROW] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  ultrasonic_ranger #(
    .CLK_FREQ   (1_000_000),
    .TRIG_US    (10),
    .PERIOD_MS  (4),
    .TIMEOUT_MS (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .echo       (echo),
    .trig       (trig),
    .disten     (disten),
    .dist_valid (dist_valid),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, req);
    end
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pops expected results on dist_valid, checks held outputs and trigger timing.
  logic [19:0] hold_d    = FAR;
  logic        hold_to   = 1'b0;
  logic        prev_trig = 1'b0;
  int          rise_cyc  = 0;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_d    = FAR;
      hold_to   = 1'b0;
      prev_trig = 1'b0;
    end else begin
      if (dist_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(dist_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("disten", 32'(disten), 32'(e.d));
          chk("timeout", 32'(timeout), 32'(e.to));
          chk("valid_cycle", cyc, e.c);
          hold_d  = e.d;
          hold_to = e.to;
        end
      end else begin
        chk("disten_hold", 32'(disten), 32'(hold_d));
        chk("timeout_hold", 32'(timeout), 32'(hold_to));
      end
      if (trig && !prev_trig) begin
        rise_cyc = cyc;
        if (trig_q.size() == 0) chk("unexpected_trig", 32'(trig), 32'd0);
        else chk("trig_rise_cycle", cyc, trig_q.pop_front());
      end
      if (!trig && prev_trig) chk("trig_width", cyc - rise_cyc, TC);
      prev_trig = trig;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    tests++;
    fails++;
    $display("FAIL watchdog: got cycle %0d, want finish before 90000", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int s, f, r, fl, vc;
    repeat (3) @(negedge clk);
    chk("reset_trig", 32'(trig), 32'd0);
    chk("reset_disten", 32'(disten), 32'(FAR));
    chk("reset_valid", 32'(dist_valid), 32'd0);
    chk("reset_timeout", 32'(timeout), 32'd0);
    trig_q.push_back(cyc + 1);
    rst_n = 1'b1;
    s = cyc + 1;

    for (int i = 0; i < NROW; i++) begin
      f = s + TC;
      trig_q.push_back(s + (hold[i] ? 2 * P : P));
      if (wid[i] == 0) begin
        exp_q.push_back(exp_t'{FAR, 1'b1, f + T});
        at_cyc(f + T + 5);
      end else begin
        r  = f + roff[i];
        fl = r + wid[i];
        vc = exp_to[i] ? f + T : fl + 3;
        exp_q.push_back(exp_t'{20'(exp_d[i]), exp_to[i], vc});
        at_cyc(r);
        echo = 1'b1;
        at_cyc(fl);
        echo = 1'b0;
      end
      s = s + (hold[i] ? 2 * P : P);
    end

    // Reset in the middle of a measurement.
    f = s + TC;
    at_cyc(f + 5);
    echo = 1'b1;
    at_cyc(f + 505);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_trig", 32'(trig), 32'd0);
    chk("midreset_disten", 32'(disten), 32'(FAR));
    chk("midreset_valid", 32'(dist_valid), 32'd0);
    chk("midreset_timeout", 32'(timeout), 32'd0);
    echo = 1'b0;
    repeat (3) @(negedge clk);
    trig_q.push_back(cyc + 1);
    rst_n = 1'b1;
    s = cyc + 1;
    f = s + TC;
    exp_q.push_back(exp_t'{20'd25, 1'b0, f + 5 + 1450 + 3});
    at_cyc(f + 5);
    echo = 1'b1;
    at_cyc(f + 5 + 1450);
    echo = 1'b0;
    at_cyc(f + 5 + 1450 + 10);

    chk("results_pending", exp_q.size(), 0);
    chk("trig_pending", trig_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
